jellyvl_synctimer_correct_sched: RTL and testbench
==================================================

# jellyvl_synctimer_correct_sched

Correction scheduler in front of the synctimer core's `correct_*` port. It arbitrates master-time samples from several requesters with round-robin priority, such as a PTP-like packet parser and an external PPS capture. It compares each sample against the local `current_time` and drives `correct_time`/`correct_valid`, asserting `correct_override` when the local timer is unlocked or too far off. A lock FSM with an optional watchdog reports lock status to software.

## Interface
- `TIMER_WIDTH`, 64, width of all time values
- `NUM_REQ`, 2, number of sample requesters (1..16)
- `LOCK_COUNT`, 4, consecutive in-threshold samples needed to reach LOCKED (1..15)
- `COMP_TIME`, 0, constant added to each accepted sample (pipeline-latency compensation, timer units)
- `TIMEOUT_WIDTH`, 32, width of watchdog counter
---
- `clk` input 1 — clock
- `reset` input 1 — asynchronous, active-low reset
- `enable` input 1 — 0: all `req_ready` low, FSM forced to UNLOCK
- `param_override_th` input TIMER_WIDTH — unsigned abs-error threshold
- `param_timeout` input TIMEOUT_WIDTH — watchdog cycles; 0 disables
- `current_time` input TIMER_WIDTH — local time from synctimer core
- `req_time` input NUM_REQ*TIMER_WIDTH — sample i at bits [i*TIMER_WIDTH +: TIMER_WIDTH]
- `req_valid` input NUM_REQ — sample present
- `req_ready` output NUM_REQ — one-hot grant
- `correct_override` output 1 — to core
- `correct_time` output TIMER_WIDTH — to core
- `correct_valid` output 1 — to core, single-cycle pulse
- `state` output 2 — 0 UNLOCK, 1 ACQUIRE, 2 LOCKED
- `locked` output 1 — `state`==LOCKED

## Operation
- **Arbiter**
  - `req_ready` = combinational one-hot grant among `req_valid` when `enable`=1.
  - Priority starts at the index after the last granted one, wrapping modulo NUM_REQ. The pointer is 0 after reset.
  - A request is accepted on `req_valid[i] & req_ready[i]`. At most one accept per cycle, back-to-back allowed.
- **Stage 1 (capture)**: register `t = req_time[i] + COMP_TIME`, modulo 2^TIMER_WIDTH, plus valid bit.
- **Stage 2 (decide)**
  - `diff = t - current_time`, modulo 2^TIMER_WIDTH, interpreted as signed.
  - Out of range when `|diff| > param_override_th`. `diff = -2^(TIMER_WIDTH-1)` always counts as out of range.
- **Output register**: `correct_time = t`, `correct_valid = 1`. `correct_override` is set by the FSM rules below.
- **FSM**, evaluated per stage-2 sample:
  - UNLOCK: override=1; good_cnt←0; →ACQUIRE.
  - ACQUIRE:
    - Out of range: override=1, good_cnt←0.
    - Otherwise: override=0, good_cnt++. When good_cnt reaches LOCK_COUNT, →LOCKED.
  - LOCKED:
    - Out of range: override=1, good_cnt←0, →ACQUIRE.
    - Otherwise: override=0.
- **Watchdog**
  - Counter clears on every `correct_valid`, otherwise increments and saturates.
  - When `param_timeout`≠0, counter ≥ `param_timeout`, and state≠UNLOCK: →UNLOCK, good_cnt←0, counter←0.
- **enable=0**
  - Pipeline valids are cleared and state→UNLOCK.
  - An in-flight sample is discarded and no `correct_valid` is issued.

## Timing
- Reset values: `req_ready`=0, `correct_valid`=0, `correct_override`=0, `correct_time`=0, `state`=UNLOCK, `locked`=0. Rr pointer, good_cnt and watchdog are all 0.
- Latency: accept in cycle N → `correct_valid` high in cycle N+2 for exactly one cycle.
- `diff` uses `current_time` as sampled in cycle N+1.
- `state`/`locked` update in the same cycle as the corresponding `correct_valid`.
- Watchdog expiry and a stage-2 sample in the same cycle: the sample wins. It is processed normally and the counter clears.
- `param_timeout` changes take effect on the next cycle's compare.
- Async reset mid-operation: all in-flight samples are dropped and outputs return to reset values immediately.
- Output `correct_valid` has no backpressure. The core accepts every cycle.

## Configuration
- `JELLYVL_SYNCTIMER_CORRECT_SCHED_WATCHDOG_EN`
  - Defined: watchdog counter and `param_timeout` behave as above.
  - Undefined: counter is not built, `param_timeout` is ignored, and the FSM leaves ACQUIRE/LOCKED only on an out-of-range sample or `enable`=0.

## Test plan
- Reset, `enable`=1, single sample on req 0 with time 1000 → `correct_valid` at N+2, `correct_time`=1000+COMP_TIME, override=1, state ACQUIRE.
- After the first sample, 4 samples each within th=8 of `current_time` → override=0 each, `locked`=1 on the 4th `correct_valid`.
- In LOCKED, a sample 100 ahead with th=8 → override=1, state ACQUIRE, good_cnt 0.
- Both reqs valid continuously → grants alternate 0,1,0,1 starting at 0, with one `correct_valid` per cycle after fill.
- LOCKED, `param_timeout`=20, no requests → state UNLOCK 20 cycles after the last `correct_valid` (watchdog macro defined). With the macro undefined → stays LOCKED.
- Sample with diff wrapping across 2^64, e.g. local 2^64-3, sample 2 → |diff|=5 ≤ th=8, override=0.

Source files
------------

// File: rtl/jellyvl_synctimer_correct_sched.sv
// jellyvl_synctimer_correct_sched
//   Correction scheduler in front of the synctimer core's correct_* port.
//   It picks master-time samples from several requesters in round-robin
//   order and compares each one against the local current_time. It then
//   issues correct_time/correct_valid, and raises correct_override while
//   the local timer is unlocked or too far off.
//   Optional watchdog: define JELLYVL_SYNCTIMER_CORRECT_SCHED_WATCHDOG_EN to
//   build the timeout counter driven by param_timeout.
module jellyvl_synctimer_correct_sched #(
    parameter int                     TIMER_WIDTH   = 64,
    parameter int                     NUM_REQ       = 2,
    parameter int                     LOCK_COUNT    = 4,
    parameter logic [TIMER_WIDTH-1:0] COMP_TIME     = '0,
    parameter int                     TIMEOUT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [TIMER_WIDTH-1:0]         param_override_th,
    input  logic [TIMEOUT_WIDTH-1:0]       param_timeout,
    input  logic [TIMER_WIDTH-1:0]         current_time,
    input  logic [NUM_REQ*TIMER_WIDTH-1:0] req_time,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           correct_override,
    output logic [TIMER_WIDTH-1:0]         correct_time,
    output logic                           correct_valid,
    output logic [1:0]                     state,
    output logic                           locked
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_UNLOCK  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [TIMER_WIDTH-1:0] DIFF_MIN = {1'b1, {(TIMER_WIDTH-1){1'b0}}};

    // unpacked view of the flattened request time bus
    logic [TIMER_WIDTH-1:0] req_time_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_time_arr[gi] = req_time[gi*TIMER_WIDTH +: TIMER_WIDTH];
    end

    // ------------------------------------------------------------------
    // round-robin arbiter
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [IDX_W-1:0]   cand;

    // first valid requester at or after the rr pointer wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = IDX_W'((32'(rr_ptr_reg) + k) % NUM_REQ);
                if (!grant_any && req_valid[cand]) begin
                    grant_any       = 1'b1;
                    grant_idx       = cand;
                    grant[cand]     = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;

    // priority moves to the requester after the one just served
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg <= '0;
        end else if (grant_any) begin
            if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr_reg <= '0;
            end else begin
                rr_ptr_reg <= grant_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // stage 1: capture accepted sample with latency compensation
    // ------------------------------------------------------------------
    logic                   s1_valid_reg;
    logic [TIMER_WIDTH-1:0] s1_time_reg;

    // latch the granted sample; enable low flushes it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            s1_time_reg  <= '0;
        end else begin
            s1_valid_reg <= enable && grant_any;
            if (grant_any) begin
                s1_time_reg <= req_time_arr[grant_idx] + COMP_TIME;
            end
        end
    end

    // ------------------------------------------------------------------
    // stage 2: error against local time
    // ------------------------------------------------------------------
    logic [TIMER_WIDTH-1:0] diff;
    logic [TIMER_WIDTH-1:0] abs_diff;
    logic                   out_of_range;

    // signed wrap-around difference; the most negative value has no
    // positive counterpart so it is always treated as out of range
    always_comb begin
        diff         = s1_time_reg - current_time;
        abs_diff     = diff[TIMER_WIDTH-1] ? ('0 - diff) : diff;
        out_of_range = (diff == DIFF_MIN) || (abs_diff > param_override_th);
    end

    // ------------------------------------------------------------------
    // watchdog
    // ------------------------------------------------------------------
    logic [1:0] state_reg;
    logic       wd_expire;
    logic       sample_take;

    assign sample_take = enable && s1_valid_reg;

`ifdef JELLYVL_SYNCTIMER_CORRECT_SCHED_WATCHDOG_EN
    logic [TIMEOUT_WIDTH-1:0] wd_cnt_reg;

    assign wd_expire = (param_timeout != '0) && (wd_cnt_reg >= param_timeout)
                       && (state_reg != ST_UNLOCK);

    // cycles since the last issued correction, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_reg <= '0;
        end else if (sample_take || wd_expire) begin
            wd_cnt_reg <= '0;
        end else if (wd_cnt_reg != '1) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end
`else
    logic unused_param_timeout;

    assign unused_param_timeout = ^param_timeout;
    assign wd_expire            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // lock FSM and output register
    // ------------------------------------------------------------------
    logic [3:0]             good_cnt_reg;
    logic                   correct_valid_reg;
    logic                   correct_override_reg;
    logic [TIMER_WIDTH-1:0] correct_time_reg;

    // one decision per stage-2 sample; a sample takes priority over expiry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg            <= ST_UNLOCK;
            good_cnt_reg         <= '0;
            correct_valid_reg    <= 1'b0;
            correct_override_reg <= 1'b0;
            correct_time_reg     <= '0;
        end else if (!enable) begin
            state_reg         <= ST_UNLOCK;
            good_cnt_reg      <= '0;
            correct_valid_reg <= 1'b0;
        end else if (s1_valid_reg) begin
            correct_valid_reg <= 1'b1;
            correct_time_reg  <= s1_time_reg;
            case (state_reg)
                ST_UNLOCK: begin
                    correct_override_reg <= 1'b1;
                    good_cnt_reg         <= '0;
                    state_reg            <= ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (out_of_range) begin
                        correct_override_reg <= 1'b1;
                        good_cnt_reg         <= '0;
                    end else begin
                        correct_override_reg <= 1'b0;
                        good_cnt_reg         <= good_cnt_reg + 4'd1;
                        if (good_cnt_reg + 4'd1 == 4'(LOCK_COUNT)) begin
                            state_reg <= ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (out_of_range) begin
                        correct_override_reg <= 1'b1;
                        good_cnt_reg         <= '0;
                        state_reg            <= ST_ACQUIRE;
                    end else begin
                        correct_override_reg <= 1'b0;
                    end
                end
                default: begin
                    correct_override_reg <= 1'b1;
                    good_cnt_reg         <= '0;
                    state_reg            <= ST_UNLOCK;
                end
            endcase
        end else begin
            correct_valid_reg <= 1'b0;
            if (wd_expire) begin
                state_reg    <= ST_UNLOCK;
                good_cnt_reg <= '0;
            end
        end
    end

    assign correct_valid    = correct_valid_reg;
    assign correct_override = correct_override_reg;
    assign correct_time     = correct_time_reg;
    assign state            = state_reg;
    assign locked           = (state_reg == ST_LOCKED);

endmodule

// File: tb/tb_jellyvl_synctimer_correct_sched.sv
// Directed testbench for jellyvl_synctimer_correct_sched (2 requesters,
// 64-bit time, LOCK_COUNT 4). Expected values are hand-computed constants.
module tb_jellyvl_synctimer_correct_sched;

    localparam int W  = 64;
    localparam int NR = 2;

    localparam logic [1:0] S_UNLOCK  = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    logic              clk;
    logic              reset;
    logic              enable;
    logic [W-1:0]      param_override_th;
    logic [31:0]       param_timeout;
    logic [W-1:0]      current_time;
    logic [NR*W-1:0]   req_time;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic              correct_override;
    logic [W-1:0]      correct_time;
    logic              correct_valid;
    logic [1:0]        state;
    logic              locked;

    int checks   = 0;
    int failures = 0;

    jellyvl_synctimer_correct_sched #(
        .TIMER_WIDTH   (W),
        .NUM_REQ       (NR),
        .LOCK_COUNT    (4),
        .COMP_TIME     (64'd0),
        .TIMEOUT_WIDTH (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .param_override_th (param_override_th),
        .param_timeout     (param_timeout),
        .current_time      (current_time),
        .req_time          (req_time),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .correct_override  (correct_override),
        .correct_time      (correct_time),
        .correct_valid     (correct_valid),
        .state             (state),
        .locked            (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one sample on requester idx, full latency walk and output checks
    task automatic send_one(input int idx, input logic [W-1:0] t,
                            input logic exp_ovr, input logic [1:0] exp_state,
                            input string name);
        logic [NR-1:0] exp_rdy;
        exp_rdy = '0;
        exp_rdy[idx] = 1'b1;
        @(posedge clk); #1;
        req_time[idx*W +: W] = t;
        req_valid[idx] = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL %s ready: got %b expected %b", name, req_ready, exp_rdy);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (correct_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s early_valid: got %b expected 0", name, correct_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (correct_valid !== 1'b1 || correct_time !== t || correct_override !== exp_ovr
            || state !== exp_state || locked !== (exp_state == S_LOCKED)) begin
            failures++;
            $display("FAIL %s out: got v=%b t=%0d ovr=%b st=%0d lk=%b expected v=1 t=%0d ovr=%b st=%0d",
                     name, correct_valid, correct_time, correct_override, state, locked,
                     t, exp_ovr, exp_state);
        end
        $display("txn %s: req%0d t=%0d -> ovr=%b state=%0d", name, idx, t, correct_override, state);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (correct_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s pulse_width: got %b expected 0", name, correct_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b0;
        param_override_th = 64'd8;
        param_timeout = 32'd0;
        current_time = 64'd0;
        req_time = '0;
        req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || correct_valid !== 1'b0 || correct_override !== 1'b0
            || correct_time !== 64'd0 || state !== S_UNLOCK || locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got rdy=%b v=%b ovr=%b t=%0d st=%0d lk=%b expected all zero",
                     req_ready, correct_valid, correct_override, correct_time, state, locked);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        enable = 1'b1;
    endtask

    task automatic test_first_sample();
        current_time = 64'd1000;
        send_one(0, 64'd1000, 1'b1, S_ACQUIRE, "first_sample");
    endtask

    task automatic test_lock();
        current_time = 64'd2000;
        send_one(0, 64'd2003, 1'b0, S_ACQUIRE, "lock_1");
        send_one(0, 64'd1995, 1'b0, S_ACQUIRE, "lock_2");
        send_one(0, 64'd2008, 1'b0, S_ACQUIRE, "lock_3_at_th");
        send_one(0, 64'd2000, 1'b0, S_LOCKED,  "lock_4");
    endtask

    task automatic test_out_of_range();
        current_time = 64'd2000;
        send_one(0, 64'd2100, 1'b1, S_ACQUIRE, "oor_ahead100");
        send_one(0, 64'd2009, 1'b1, S_ACQUIRE, "oor_th_plus1");
        // good count restarted: three good samples are not enough
        send_one(0, 64'd2000, 1'b0, S_ACQUIRE, "relock_1");
        send_one(0, 64'd2000, 1'b0, S_ACQUIRE, "relock_2");
        send_one(0, 64'd2000, 1'b0, S_ACQUIRE, "relock_3");
        send_one(0, 64'd2000, 1'b0, S_LOCKED,  "relock_4");
    endtask

    task automatic test_wrap();
        current_time = 64'hFFFF_FFFF_FFFF_FFFD;
        send_one(0, 64'd2, 1'b0, S_LOCKED, "wrap_diff5");
        // most negative difference is out of range even with a maximal threshold
        param_override_th = '1;
        current_time = 64'd0;
        send_one(0, 64'h8000_0000_0000_0000, 1'b1, S_ACQUIRE, "diff_min");
        param_override_th = 64'd8;
    endtask

    task automatic test_enable();
        @(posedge clk); #1;
        current_time = 64'd3000;
        req_time[0 +: W] = 64'd3000;
        req_valid = 2'b01;
        @(negedge clk);
        @(posedge clk); #1;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL enable_low_ready: got %b expected 00", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (correct_valid !== 1'b0 || state !== S_UNLOCK) begin
            failures++;
            $display("FAIL enable_low_flush: got v=%b st=%0d expected v=0 st=0", correct_valid, state);
        end
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (correct_valid !== 1'b0) begin
            failures++;
            $display("FAIL enable_restore: got v=%b expected 0", correct_valid);
        end
        $display("txn enable_low: in-flight sample dropped, state=%0d", state);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_st;
        logic [W-1:0] exp_t;
        // async reset with a sample in flight
        @(posedge clk); #1;
        req_time[0 +: W] = 64'd7777;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = '0;
        reset = 1'b0;
        #1;
        checks++;
        if (correct_valid !== 1'b0 || correct_time !== 64'd0 || state !== S_UNLOCK) begin
            failures++;
            $display("FAIL async_reset: got v=%b t=%0d st=%0d expected 0 0 0",
                     correct_valid, correct_time, state);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (correct_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_drop: got v=%b expected 0", correct_valid);
        end
        // both requesters continuously valid
        param_override_th = 64'd2000;
        current_time = 64'd5000;
        @(posedge clk); #1;
        req_time[0 +: W] = 64'd5000;
        req_time[W +: W] = 64'd6000;
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) req_valid = '0;
            @(negedge clk);
            if (k < 6) begin
                checks++;
                if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    failures++;
                    $display("FAIL b2b_grant%0d: got %b expected %b", k, req_ready,
                             (k % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            if (k >= 2) begin
                exp_t  = ((k - 2) % 2 == 0) ? 64'd5000 : 64'd6000;
                exp_st = (k - 2 < 4) ? S_ACQUIRE : S_LOCKED;
                checks++;
                if (correct_valid !== 1'b1 || correct_time !== exp_t
                    || correct_override !== (k == 2) || state !== exp_st) begin
                    failures++;
                    $display("FAIL b2b_out%0d: got v=%b t=%0d ovr=%b st=%0d expected v=1 t=%0d ovr=%b st=%0d",
                             k - 2, correct_valid, correct_time, correct_override, state,
                             exp_t, (k == 2), exp_st);
                end
                $display("txn b2b_out%0d: t=%0d ovr=%b state=%0d", k - 2, correct_time,
                         correct_override, state);
            end
            @(posedge clk); #1;
        end
    endtask

    // entered one cycle after the last correct_valid
    task automatic test_watchdog();
        param_override_th = 64'd8;
        param_timeout = 32'd20;
        repeat (18) @(posedge clk);
        @(negedge clk);
        checks++;
        if (state !== S_LOCKED) begin
            failures++;
            $display("FAIL wd_before: got st=%0d expected %0d", state, S_LOCKED);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
`ifdef JELLYVL_SYNCTIMER_CORRECT_SCHED_WATCHDOG_EN
        if (state !== S_UNLOCK || locked !== 1'b0) begin
            failures++;
            $display("FAIL wd_expire: got st=%0d lk=%b expected st=0 lk=0", state, locked);
        end
`else
        if (state !== S_LOCKED || locked !== 1'b1) begin
            failures++;
            $display("FAIL wd_absent: got st=%0d lk=%b expected st=2 lk=1", state, locked);
        end
`endif
        $display("txn watchdog: timeout=20 state=%0d", state);
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_lock();
        test_out_of_range();
        test_wrap();
        test_enable();
        test_back_to_back();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
